// File: rtl/switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// switch_allocator_rr
//
// Allocates crossbar outputs to input ports for wormhole packets. Each input
// runs a small FSM (IDLE -> REQ -> GRANT -> HELD). Each output has its own
// round-robin arbiter, so a requester waiting on an output is never starved.
// An output stays owned from the winning edge until its owner pulses release.
// INPUTS and OUTPUTS are independent, so non-square routers are supported.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous, active-low reset
//   req_valid     [INPUTS]              level request per input
//   req_dest      [INPUTS][DEST_WIDTH]  requested output per input
//   release_i     [INPUTS]              one-cycle pulse after the tail flit
//   grant         [INPUTS]              one-cycle acknowledge (GRANT state)
//   reserved      [INPUTS]              input holds an output (HELD state)
//   route_select  [OUTPUTS][SEL_WIDTH]  owning input per output (crossbar select)
//   output_busy   [OUTPUTS]             output currently owned
//
// "release" is a reserved word in SystemVerilog, so the release port is
// named release_i.
// -----------------------------------------------------------------------------
module switch_allocator_rr #(
    parameter int INPUTS     = 5,
    parameter int OUTPUTS    = 5,
    parameter int DEST_WIDTH = $clog2(OUTPUTS),
    parameter int SEL_WIDTH  = $clog2(INPUTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INPUTS-1:0]                   req_valid,
    input  logic [INPUTS-1:0][DEST_WIDTH-1:0]   req_dest,
    input  logic [INPUTS-1:0]                   release_i,
    output logic [INPUTS-1:0]                   grant,
    output logic [INPUTS-1:0]                   reserved,
    output logic [OUTPUTS-1:0][SEL_WIDTH-1:0]   route_select,
    output logic [OUTPUTS-1:0]                  output_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_GRANT = 2'd2,
        S_HELD  = 2'd3
    } in_state_e;

    in_state_e                         state_q [INPUTS];
    in_state_e                         state_d [INPUTS];

    logic [OUTPUTS-1:0]                busy_q, busy_d;
    logic [OUTPUTS-1:0][SEL_WIDTH-1:0] sel_q,  sel_d;
    logic [OUTPUTS-1:0][SEL_WIDTH-1:0] ptr_q,  ptr_d;

    logic [OUTPUTS-1:0]                win_vld;
    logic [SEL_WIDTH-1:0]              win_idx [OUTPUTS];
    logic [INPUTS-1:0]                 in_won;
    logic [OUTPUTS-1:0]                rel_clr;

    // Per-output round-robin search. Only free outputs arbitrate, and busy_q is
    // the registered value, so an output freed on this edge cannot be won on
    // the same edge (one bubble cycle). A withdrawing input has req_valid=0 and
    // therefore is never a candidate. Illegal destinations never match any o.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            win_idx[o] = '0;
            if (!busy_q[o]) begin
                for (int k = 0; k < INPUTS; k++) begin
                    idx = int'(ptr_q[o]) + k;
                    if (idx >= INPUTS) begin
                        idx = idx - INPUTS;
                    end
                    if (!win_vld[o] && (state_q[idx] == S_REQ) && req_valid[idx]
                        && (int'(req_dest[idx]) == o)) begin
                        win_vld[o] = 1'b1;
                        win_idx[o] = SEL_WIDTH'(idx);
                    end
                end
            end
        end
    end

    // Map output winners back to inputs. Each input names a single destination,
    // so at most one output can pick any given input.
    always_comb begin
        in_won = '0;
        for (int i = 0; i < INPUTS; i++) begin
            for (int o = 0; o < OUTPUTS; o++) begin
                if (win_vld[o] && (int'(win_idx[o]) == i)) begin
                    in_won[i] = 1'b1;
                end
            end
        end
    end

    // An output is freed when its recorded owner is in HELD and pulses release.
    always_comb begin
        rel_clr = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (busy_q[o] && (int'(sel_q[o]) == i)
                    && (state_q[i] == S_HELD) && release_i[i]) begin
                    rel_clr[o] = 1'b1;
                end
            end
        end
    end

    // Output-side next state. route_select deliberately keeps its value after
    // release; only output_busy says whether the select is meaningful.
    always_comb begin
        int nxt;
        nxt    = 0;
        busy_d = busy_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (rel_clr[o]) begin
                busy_d[o] = 1'b0;
            end
            if (win_vld[o]) begin
                nxt = int'(win_idx[o]) + 1;
                if (nxt >= INPUTS) begin
                    nxt = 0;
                end
                busy_d[o] = 1'b1;
                sel_d[o]  = win_idx[o];
                ptr_d[o]  = SEL_WIDTH'(nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
        end
    end

    // Per-input FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < INPUTS; i++) begin
                state_q[i] <= S_IDLE;
            end
        end else begin
            state_q <= state_d;
        end
    end

    // Per-input FSM next state and Moore outputs.
    always_comb begin
        grant    = '0;
        reserved = '0;
        for (int i = 0; i < INPUTS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (req_valid[i]) begin
                        state_d[i] = S_REQ;
                    end
                end
                S_REQ: begin
                    if (!req_valid[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (in_won[i]) begin
                        state_d[i] = S_GRANT;
                    end
                end
                S_GRANT: begin
                    grant[i]   = 1'b1;
                    state_d[i] = S_HELD;
                end
                S_HELD: begin
                    reserved[i] = 1'b1;
                    if (release_i[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase
        end
    end

    assign route_select = sel_q;
    assign output_busy  = busy_q;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator_rr
//
// Directed bench for switch_allocator_rr. u5 is the square 5x5 router, u3 is a
// 5-input / 3-output router used for independent outputs and an illegal
// destination. Inputs are driven and outputs sampled 1 time unit after the
// rising edge. "Cycle 0" is the cycle in which a request is first driven.
// -----------------------------------------------------------------------------
module tb_switch_allocator_rr;

    logic clk;
    logic rst;

    logic [4:0]       rv5, rel5, g5, r5, ob5;
    logic [4:0][2:0]  rd5;
    logic [4:0][2:0]  rs5;

    logic [4:0]       rv3, rel3, g3, r3;
    logic [4:0][1:0]  rd3;
    logic [2:0][2:0]  rs3;
    logic [2:0]       ob3;

    int n_vec;
    int n_err;
    int held [5];
    int gcnt [5];
    int exp_ord [6];
    int exp_cyc [6];
    int ng;
    int last_rel;
    int seen;

    switch_allocator_rr #(.INPUTS(5), .OUTPUTS(5)) u5 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (rv5),
        .req_dest    (rd5),
        .release_i   (rel5),
        .grant       (g5),
        .reserved    (r5),
        .route_select(rs5),
        .output_busy (ob5)
    );

    switch_allocator_rr #(.INPUTS(5), .OUTPUTS(3)) u3 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (rv3),
        .req_dest    (rd3),
        .release_i   (rel3),
        .grant       (g3),
        .reserved    (r3),
        .route_select(rs3),
        .output_busy (ob3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rv5 = '0; rel5 = '0; rd5 = '0;
        rv3 = '0; rel3 = '0; rd3 = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        // ---------------- reset state ----------------
        chk("rst_busy",   int'(ob5), 0);
        chk("rst_sel",    int'(rs5), 0);
        chk("rst_grant",  int'(g5),  0);
        chk("rst_resv",   int'(r5),  0);
        chk("rst_busy3",  int'(ob3), 0);
        rst = 1'b1;
        tick();

        // ---------------- single uncontended request ----------------
        rd5[2] = 3'd4; rv5[2] = 1'b1;                 // cycle 0
        chk("t1_c0_grant", int'(g5), 0);
        tick();                                       // cycle 1
        chk("t1_c1_grant", int'(g5), 0);
        tick();                                       // cycle 2
        chk("t1_c2_grant", int'(g5), 5'b00100);
        chk("t1_sel4",     int'(rs5[4]), 2);
        chk("t1_busy",     int'(ob5), 5'b10000);
        chk("t1_c2_resv",  int'(r5), 0);
        rv5[2] = 1'b0;
        tick();                                       // cycle 3
        chk("t1_c3_grant", int'(g5), 0);
        chk("t1_c3_resv",  int'(r5), 5'b00100);
        rel5[2] = 1'b1;
        tick();                                       // cycle 4
        rel5 = '0;
        chk("t1_rel_busy", int'(ob5), 0);
        chk("t1_rel_resv", int'(r5), 0);
        chk("t1_sel_keep", int'(rs5[4]), 2);
        tick();

        // ---------------- round-robin fairness on output 1 ----------------
        exp_ord = '{0, 1, 3, 0, 1, 3};
        exp_cyc = '{2, 6, 10, 14, 18, 22};
        for (int i = 0; i < 5; i++) begin
            held[i] = 0;
            gcnt[i] = 0;
        end
        ng = 0;
        last_rel = -100;
        rd5[0] = 3'd1; rd5[1] = 3'd1; rd5[3] = 3'd1;
        rv5 = 5'b01011;
        for (int c = 0; c < 32; c++) begin
            rel5 = '0;
            for (int i = 0; i < 5; i++) begin
                if (g5[i]) begin
                    if (ng < 6) begin
                        chk("rr_order", i, exp_ord[ng]);
                        chk("rr_cycle", c, exp_cyc[ng]);
                    end
                    chk("rr_bubble", int'((c - last_rel) >= 2), 1);
                    ng++;
                    gcnt[i]++;
                    rv5[i] = 1'b0;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (r5[i]) begin
                    if (held[i] == 1) begin
                        rel5[i] = 1'b1;
                        held[i] = 0;
                        last_rel = c;
                        if (gcnt[i] < 2) rv5[i] = 1'b1;
                    end else begin
                        held[i] = held[i] + 1;
                    end
                end
            end
            tick();
        end
        rel5 = '0;
        chk("rr_count", ng, 6);
        chk("rr_idle_busy", int'(ob5), 0);

        // ---------------- pointer wrap-around on output 2 ----------------
        rd5[3] = 3'd2; rv5 = 5'b01000;                // cycle 0
        tick(); tick();                               // cycle 2
        chk("wr_g3", int'(g5), 5'b01000);
        rv5 = '0;
        tick();                                       // cycle 3
        rel5[3] = 1'b1;
        tick();                                       // cycle 4
        rel5 = '0;
        rd5[0] = 3'd2; rd5[4] = 3'd2; rv5 = 5'b10001;
        tick(); tick();                               // cycle 6
        chk("wr_g4",   int'(g5), 5'b10000);
        chk("wr_sel4", int'(rs5[2]), 4);
        rv5[4] = 1'b0;
        tick();                                       // cycle 7
        chk("wr_r4", int'(r5), 5'b10000);
        rel5[4] = 1'b1;
        tick();                                       // cycle 8
        rel5 = '0;
        chk("wr_free",   int'(ob5[2]), 0);
        chk("wr_bubble", int'(g5), 0);
        tick();                                       // cycle 9
        chk("wr_g0",   int'(g5), 5'b00001);
        chk("wr_sel0", int'(rs5[2]), 0);
        rv5 = '0;
        tick();
        rel5[0] = 1'b1;
        tick();
        rel5 = '0;
        tick();

        // ---------------- withdrawal on output 0 ----------------
        rd5[4] = 3'd0; rv5 = 5'b10000;                // cycle 0
        tick(); tick();                               // cycle 2
        chk("wd_own_grant", int'(g5), 5'b10000);
        rv5 = '0;
        tick();                                       // cycle 3
        chk("wd_own_resv", int'(r5), 5'b10000);
        rd5[1] = 3'd0; rd5[3] = 3'd0; rv5 = 5'b01010;
        seen = 0;
        for (int c = 4; c <= 9; c++) begin
            tick();
            rel5 = '0;
            if (g5 != 5'b00000) seen = 1;
            if (c == 6) rv5[1] = 1'b0;
            if (c == 8) rel5[4] = 1'b1;
        end
        chk("wd_wait_nogrant", seen, 0);
        chk("wd_free",         int'(ob5[0]), 0);
        tick();                                       // cycle 10
        chk("wd_next_grant", int'(g5), 5'b01000);
        chk("wd_next_sel",   int'(rs5[0]), 3);
        rv5 = '0;
        tick();
        rel5[3] = 1'b1;
        tick();
        rel5 = '0;
        tick();
        rd5[1] = 3'd0; rv5 = 5'b00010;                // fresh request from IDLE
        tick();
        chk("wd_relat_c1", int'(g5), 0);
        tick();
        chk("wd_relat_c2", int'(g5), 5'b00010);
        rv5 = '0;
        tick();
        rel5[1] = 1'b1;
        tick();
        rel5 = '0;

        // ---------------- independent outputs and illegal destination ----------------
        rd3[0] = 2'd0; rd3[1] = 2'd1; rd3[2] = 2'd2; rd3[4] = 2'd3;
        rv3 = 5'b10111;                               // cycle 0
        seen = 0;
        tick(); tick();                               // cycle 2
        chk("io_grants", int'(g3), 5'b00111);
        chk("io_busy",   int'(ob3), 3'b111);
        chk("io_sel1",   int'(rs3[1]), 1);
        chk("io_sel2",   int'(rs3[2]), 2);
        rv3 = 5'b10000;
        tick();                                       // cycle 3
        chk("io_resv", int'(r3), 5'b00111);
        rel3 = 5'b00111;
        tick();                                       // cycle 4
        rel3 = '0;
        for (int c = 5; c <= 24; c++) begin
            tick();
            if (g3[4] || r3[4]) seen = 1;
        end
        chk("io_illegal", seen, 0);
        chk("io_freed",   int'(ob3), 0);
        rv3 = '0;
        tick();

        // ---------------- asynchronous reset mid-packet ----------------
        rd5[0] = 3'd3; rd5[1] = 3'd2; rv5 = 5'b00011; // cycle 0
        tick(); tick();                               // cycle 2
        chk("ar_grants", int'(g5), 5'b00011);
        rv5 = '0;
        tick();                                       // cycle 3
        chk("ar_busy_pre", int'(ob5), 5'b01100);
        chk("ar_resv_pre", int'(r5), 5'b00011);
        #3 rst = 1'b0;
        #1;
        chk("ar_busy", int'(ob5), 0);
        chk("ar_resv", int'(r5),  0);
        chk("ar_sel",  int'(rs5), 0);
        #2 rst = 1'b1;
        tick();
        chk("ar_resv_after", int'(r5), 0);
        rd5[3] = 3'd0; rv5 = 5'b01000;                // cycle 0
        tick();
        chk("ar_lat_c1", int'(g5), 0);
        tick();
        chk("ar_lat_c2", int'(g5), 5'b01000);
        chk("ar_sel0",   int'(rs5[0]), 3);
        rv5 = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
